// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types and helpers for the branch resolve unit
package bru_pkg;

  // Resolution FSM states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  // One in-flight predicted branch
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bru_entry_t;

  // Fall-through distance for a not-taken branch
  localparam logic [31:0] PC_STEP = 32'd4;

  // A branch is mispredicted if the direction differs, or both say taken
  // but the targets disagree
  function automatic logic is_mispredict(input bru_entry_t  e,
                                         input logic        act_taken,
                                         input logic [31:0] act_target);
    logic dir_miss;
    logic tgt_miss;
    dir_miss = (e.taken != act_taken);
    tgt_miss = e.taken && act_taken && (e.target != act_target);
    return dir_miss || tgt_miss;
  endfunction

endpackage

// File: rtl/bru_fifo.sv
// rtl/bru_fifo.sv - in-order queue of in-flight predicted branches
module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  bru_entry_t                 push_data,
  input  logic                       pop,
  input  logic                       clear,
  output bru_entry_t                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  bru_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  // Storage write; a push in the same edge as clear is a younger branch and is dropped
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; clear empties the queue regardless of push/pop
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves predicted branches, trains predictor, redirects fetch
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        update_en,
  output logic [31:0] update_pc,
  output logic        actual_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_e             state_q, state_d;
  logic [FC_W-1:0]        fcnt_q, fcnt_d;

  bru_entry_t             push_entry;
  bru_entry_t             head;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic                   q_empty;

  logic                   do_push;
  logic                   do_pop;
  logic                   mispred;
  logic                   do_clear;

  // pred_ready looks at the pre-pop occupancy so it never depends on res_valid
  assign pred_ready = (state_q == ST_RUN) && !q_full;
  assign do_push    = pred_valid && pred_ready;
  assign do_pop     = res_valid && (state_q == ST_RUN) && !q_empty;
  assign mispred    = is_mispredict(head, res_taken, res_target);
  assign do_clear   = do_pop && mispred;

  assign push_entry.pc     = pred_pc;
  assign push_entry.taken  = pred_taken;
  assign push_entry.target = pred_target;

  bru_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .clear     (do_clear),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // FSM state and flush-length counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: a mispredict pop enters FLUSH, which lasts FLUSH_CYCLES cycles
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN: begin
        if (do_clear) begin
          state_d = ST_FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign flush = (state_q == ST_FLUSH);

  // Training, redirect strobes and statistics, one cycle after the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      update_en      <= 1'b0;
      update_pc      <= '0;
      actual_taken   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
    end else begin
      update_en      <= do_pop;
      redirect_valid <= do_clear;
      if (do_pop) begin
        update_pc    <= head.pc;
        actual_taken <= res_taken;
        branch_cnt   <= branch_cnt + 32'd1;
      end
      if (do_clear) begin
        redirect_pc <= res_taken ? res_target : (head.pc + PC_STEP);
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, q_count};

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution end of the bimodal direction-prediction path.
- Tracks in-flight predicted branches in program order, from fetch to execute.
- When execute resolves each branch, the block compares the actual outcome against the stored prediction and drives the predictor training interface: update_en, update_pc, actual_taken.
- On a mispredict it issues a fetch redirect and a timed pipeline flush.

Parameters:
- DEPTH, 4: in-flight branch queue entries; power of 2, minimum 2.
- FLUSH_CYCLES, 2: cycles flush stays high after a mispredict; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  fetch presents a predicted conditional branch.
- pred_pc  in  32  branch instruction PC.
- pred_taken  in  1  predicted direction, 1 = taken.
- pred_target  in  32  predicted target; meaningful only when pred_taken = 1.
- pred_ready  out  1  queue can accept an entry.
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_taken  in  1  actual direction.
- res_target  in  32  actual computed target.
- update_en  out  1  one-cycle predictor training strobe.
- update_pc  out  32  PC of the resolved branch.
- actual_taken  out  1  resolved direction for the predictor.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  correct next PC.
- flush  out  1  kill younger in-flight instructions.
- branch_cnt  out  32  resolved branches counter.
- mispred_cnt  out  32  mispredicts counter.

Behaviour:
- Reset (rst = 1 at a clock edge; may occur mid-flush or with a full queue):
  - queue emptied, state RUN.
  - All outputs 0, including both counters.
  - pred_ready is 1 in the first cycle after reset.
- States: RUN and FLUSH.
  - pred_ready = (state == RUN) and count < DEPTH.
  - Push when pred_valid and pred_ready.
  - Pop when res_valid, state == RUN and count > 0.
  - res_valid with an empty queue, or while in FLUSH, is ignored: no pop, no strobe, no counter change.
- Push and pop in the same cycle: both take effect; count is unchanged. This is legal when the queue is full, because pred_ready is evaluated on the pre-pop count.
- Pointers wrap modulo DEPTH.
- Mispredict, evaluated against the popped head entry:
  - condition is (pred_taken != res_taken), or (pred_taken and res_taken and pred_target != res_target).
- Outputs are registered, with one-cycle latency from the pop:
  - update_en = 1, update_pc = head pc, actual_taken = res_taken.
  - branch_cnt increments by 1.
- On mispredict, in the same cycle as update_en:
  - redirect_valid = 1.
  - redirect_pc = res_target if res_taken, else head pc + 4 (mod 2^32).
  - mispred_cnt increments by 1.
  - Queue is cleared in the same edge as the pop. A push coinciding with the mispredict pop is discarded (it is a younger branch).
  - state moves to FLUSH; flush = 1 for exactly FLUSH_CYCLES cycles, the first coinciding with redirect_valid.
  - After FLUSH_CYCLES cycles the state returns to RUN. pred_ready reasserts in the cycle after flush drops.
- update_en, redirect_valid and flush are 0 at all other times.
- update_pc, actual_taken and redirect_pc hold their last values when their strobes are low.
- Counters wrap at 2^32.

Decomposition:
- Package bru_pkg holds:
  - the state enum (ST_RUN, ST_FLUSH);
  - an entry struct {pc[31:0], taken, target[31:0]};
  - the PC_STEP = 4 constant.
- One sub-module, bru_fifo: synchronous FIFO parameterised by DEPTH, with push, pop, clear, and count/full/empty flags.
- Comparison, FSM and counters stay in the top level.

Test Plan:
- Reset and first pred:
  - Stimulus: reset, then push pc = 0x100 with pred_taken = 0; resolve res_taken = 0.
  - Required: one cycle later update_en = 1, update_pc = 0x100, actual_taken = 0; no redirect; branch_cnt = 1, mispred_cnt = 0.
- Direction mispredict:
  - Stimulus: push pc = 0x200, pred_taken = 0; resolve res_taken = 1, res_target = 0x80.
  - Required: redirect_valid = 1 with redirect_pc = 0x80; flush high 2 cycles; pred_ready = 0 during flush; mispred_cnt = 1.
- Target mispredict, taken/taken:
  - Stimulus: push pc = 0x300, taken, target 0x400; resolve taken, target 0x404.
  - Required: redirect_pc = 0x404, mispred_cnt increments.
  - Second case: pred taken, resolve not-taken at pc = 0xFFFFFFFC. Required: redirect_pc = 0x00000000.
- Full queue:
  - Stimulus: push 4 entries with no resolves.
  - Required: pred_ready = 0; a 5th pred_valid is not accepted.
  - Then resolve and push in the same cycle. Required: accepted, count stays 4, and entries drain in order 0x10, 0x20, 0x30, 0x40, 0x50.
- Mispredict clears younger entries:
  - Stimulus: 3 entries queued; head mispredicts while pred_valid is high.
  - Required: the queue is empty after flush; res_valid during flush produces no update_en.
  - Then assert rst during FLUSH. Required: flush = 0, pred_ready = 1 the next cycle, counters = 0.
